ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 CLK_FREQ_HZ, 50_000_000, system clock frequency; derives INHIBIT_CYC = CLK_FREQ_HZ/10_000 (100 us) and TIMEOUT_CYC = CLK_FREQ_HZ/50 (20 ms).
REQ-002 FILTER_LEN, 8, cycles a synchronized PS/2 line must hold a value before the filtered level changes.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  system clock.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 tx_data_i  in  8  command byte to send to the device.
REQ-007 tx_valid_i  in  1  byte request; accepted when tx_valid_i and tx_ready_o are both 1.
REQ-008 tx_ready_o  out  1  high only in IDLE.
REQ-009 ps2c_i / ps2d_i  in  1 each  raw pad levels of PS/2 clock and data (asynchronous).
REQ-010 ps2c_oe_o / ps2d_oe_o  out  1 each  1 = pull line low (open drain); 0 = release.
REQ-011 busy_o  out  1  high in every state except IDLE; lets the PS/2 receiver ignore frames.
REQ-012 done_o  out  1  one-cycle pulse when a frame completes (ACK received or not).
REQ-013 ack_err_o  out  1  valid with done_o; 1 = device did not hold data low at the 11th falling clock edge.
REQ-014 timeout_o  out  1  one-cycle pulse when the watchdog expires.

Function
REQ-015 Each raw line SHALL pass a 2-flop synchronizer, then a FILTER_LEN stability filter; filtered levels reset to 1. A falling edge is filtered clock going 1->0.
REQ-016 States: IDLE, INHIBIT, REQ, BITS, ACK, WAIT_REL, DONE.
REQ-017 IDLE: on accept, latch tx_data_i, compute odd parity (parity = ~^data), clear counters, go INHIBIT next cycle.
REQ-018 INHIBIT: ps2c_oe_o = 1 for exactly INHIBIT_CYC cycles; in the last of those cycles ps2d_oe_o also asserts (start bit); then go REQ.
REQ-019 REQ: ps2c_oe_o = 0, ps2d_oe_o = 1; watchdog starts counting; on the first falling edge drive bit 0 and go BITS with bit index 1.
REQ-020 BITS: on each falling edge present the next bit (d1..d7, then parity, then stop = release); ps2d_oe_o = ~bit; data changes only in the cycle after a detected falling edge.
REQ-021 After stop is presented (10th falling edge) go ACK; on the 11th falling edge sample filtered data: 0 -> ack_err = 0, 1 -> ack_err = 1; go WAIT_REL.
REQ-022 WAIT_REL: wait until filtered clock and data are both 1, then DONE.
REQ-023 DONE: pulse done_o with ack_err_o for one cycle, return to IDLE; tx_ready_o high the following cycle.
REQ-024 Watchdog: counts from REQ entry to DONE; reaching TIMEOUT_CYC in any state releases both lines in the same cycle, pulses timeout_o, returns to IDLE; done_o is not pulsed.
REQ-025 tx_valid_i while busy_o = 1 SHALL be ignored; there is no queueing.
REQ-026 Line glitches shorter than FILTER_LEN cycles SHALL NOT count as edges.
REQ-027 ps2c_oe_o and ps2d_oe_o are registered outputs; never both toggled by a glitch.

Reset
REQ-028 On the rising clk_i edge where rst_i = 1: state = IDLE, both oe outputs = 0, tx_ready_o = 1, busy_o = done_o = ack_err_o = timeout_o = 0, counters = 0, filtered levels = 1.
REQ-029 Reset mid-frame SHALL release both lines in that same cycle and produce no done_o or timeout_o pulse.

Structure
REQ-030 Package ps2_pkg holds the state enum, the frame bit count (11), and the odd-parity function, shared with the PS/2 receiver.
REQ-031 Sub-module ps2_line_filter (synchronizer + stability filter + falling-edge pulse), instantiated once per line.

Verification (bench: CLK_FREQ_HZ = 1_000_000, so INHIBIT_CYC = 100 and TIMEOUT_CYC = 20_000; device model clocks at 10 kHz)
REQ-032 Send 0xED, device ACKs -> clock held low 100 cycles; device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done_o = 1 with ack_err_o = 0.
REQ-033 Send 0x01, device leaves data high at the 11th edge -> parity 0 is sampled; done_o = 1 with ack_err_o = 1.
REQ-034 Send 0xFF, device never clocks -> both lines are released and timeout_o pulses exactly 20_000 cycles after REQ entry; tx_ready_o = 1 next cycle.
REQ-035 Assert rst_i at the 5th device falling edge -> both oe outputs are 0 in that cycle; no done_o; a new 0x01 request then completes normally.
REQ-036 Pulse tx_valid_i with 0xAA while busy, plus 3-cycle clock glitches during INHIBIT -> the second byte is never sent; bit index is unchanged by the glitches.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 definitions for the host transmitter and receiver
//   ps2_state_e : host transmit FSM states
//   FRAME_BITS  : clocks per PS/2 frame (start, 8 data, parity, stop/ack)
//   odd_parity  : parity bit that makes data plus parity an odd count of ones
package ps2_pkg;

   localparam int FRAME_BITS = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_BITS,
      ST_ACK,
      ST_WAIT_REL,
      ST_DONE
   } ps2_state_e;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchronizer, stability filter and falling-edge pulse
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset (filtered level resets to 1)
//   line_i  : raw asynchronous pad level
//   level_o : filtered level, changes only after FILTER_LEN stable cycles
//   fall_o  : one-cycle pulse in the first cycle level_o reads 0 after a 1
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic level_o,
   output logic fall_o
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync_q, sync_d;
   logic          level_q, level_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d  = {sync_q[0], line_i};
      level_d = level_q;
      cnt_d   = '0;
      // Any cycle that agrees with the current level restarts the run, so a
      // glitch shorter than FILTER_LEN never moves the filtered level.
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      fall_d = level_q & ~level_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//   clk_i, rst_i            : system clock, synchronous active-high reset
//   tx_data_i, tx_valid_i   : command byte request, accepted with tx_ready_o
//   tx_ready_o              : high only when idle
//   ps2c_i, ps2d_i          : raw PS/2 clock and data pad levels
//   ps2c_oe_o, ps2d_oe_o    : 1 pulls the open-drain line low
//   busy_o                  : transfer in progress
//   done_o, ack_err_o       : frame finished pulse, ack_err_o = no device ACK
//   timeout_o               : watchdog expiry pulse
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int FILTER_LEN  = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   input  logic       ps2c_i,
   input  logic       ps2d_i,
   output logic       ps2c_oe_o,
   output logic       ps2d_oe_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       ack_err_o,
   output logic       timeout_o
);

   localparam int INHIBIT_CYC = CLK_FREQ_HZ / 10_000;
   localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 50;
   localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
   localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
   // Index of the stop bit within the host-driven part of the frame.
   localparam logic [3:0]       STOP_IDX = 4'(FRAME_BITS - 2);

   logic clk_filt, clk_fall, dat_filt, dat_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .line_i  (ps2c_i),
      .level_o (clk_filt),
      .fall_o  (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .line_i  (ps2d_i),
      .level_o (dat_filt),
      .fall_o  (dat_fall_unused)
   );

   ps2_state_e       state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic             parity_q, parity_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic             c_oe_q, c_oe_d;
   logic             d_oe_q, d_oe_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;
   logic             timeout_q, timeout_d;
   logic             wd_run;
   logic [9:0]       frame_bits;

   // Bits presented on successive falling edges: d0..d7, parity, stop.
   assign frame_bits = {1'b1, parity_q, data_q};

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      parity_d  = parity_q;
      bit_idx_d = bit_idx_q;
      inh_cnt_d = inh_cnt_q;
      wd_cnt_d  = wd_cnt_q;
      c_oe_d    = c_oe_q;
      d_oe_d    = d_oe_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
      timeout_d = 1'b0;
      wd_run    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tx_valid_i) begin
               data_d    = tx_data_i;
               parity_d  = odd_parity(tx_data_i);
               bit_idx_d = '0;
               inh_cnt_d = '0;
               wd_cnt_d  = '0;
               ack_err_d = 1'b0;
               c_oe_d    = 1'b1;
               d_oe_d    = (INH_LAST == '0);
               state_d   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               c_oe_d   = 1'b0;
               d_oe_d   = 1'b1;
               wd_cnt_d = '0;
               state_d  = ST_REQ;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
               // Start bit overlaps the final inhibit cycle.
               d_oe_d    = (inh_cnt_d == INH_LAST);
            end
         end
         ST_REQ: begin
            wd_run = 1'b1;
            if (clk_fall) begin
               d_oe_d    = ~frame_bits[0];
               bit_idx_d = 4'd1;
               state_d   = ST_BITS;
            end
         end
         ST_BITS: begin
            wd_run = 1'b1;
            if (clk_fall) begin
               d_oe_d    = ~frame_bits[bit_idx_q];
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == STOP_IDX) begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            wd_run = 1'b1;
            if (clk_fall) begin
               ack_err_d = dat_filt;
               state_d   = ST_WAIT_REL;
            end
         end
         ST_WAIT_REL: begin
            wd_run = 1'b1;
            if (clk_filt && dat_filt) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            c_oe_d  = 1'b0;
            d_oe_d  = 1'b0;
         end
      endcase

      // Watchdog overrides whatever the state wanted this cycle.
      if (wd_run) begin
         if (wd_cnt_q == WD_LAST) begin
            state_d   = ST_IDLE;
            c_oe_d    = 1'b0;
            d_oe_d    = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b1;
         end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         parity_q  <= 1'b0;
         bit_idx_q <= '0;
         inh_cnt_q <= '0;
         wd_cnt_q  <= '0;
         c_oe_q    <= 1'b0;
         d_oe_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         parity_q  <= parity_d;
         bit_idx_q <= bit_idx_d;
         inh_cnt_q <= inh_cnt_d;
         wd_cnt_q  <= wd_cnt_d;
         c_oe_q    <= c_oe_d;
         d_oe_q    <= d_oe_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         timeout_q <= timeout_d;
      end
   end

   assign tx_ready_o = (state_q == ST_IDLE);
   assign busy_o     = (state_q != ST_IDLE);
   assign ps2c_oe_o  = c_oe_q;
   assign ps2d_oe_o  = d_oe_q;
   assign done_o     = done_q;
   assign ack_err_o  = ack_err_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized bench for ps2_host_tx with a 10 kHz PS/2 device model
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2c_i, ps2d_i, ps2c_oe, ps2d_oe;
   logic       busy, done, ack_err, timeout;
   logic       dev_c = 1'b1, dev_d = 1'b1, glitch_c = 1'b0;

   int checks = 0, failures = 0, cyc = 0;

   // Monitor state
   int done_cnt = 0, to_cnt = 0, to_cycle = 0, req_cycle = 0;
   int frame_starts = 0, inh_len = 0, inh_d = 0, last_inh = 0, last_inh_d = 0;
   int last_ack_err = 0, to_c_oe = 0, to_d_oe = 0, to_ready_next = 0;
   bit to_pending = 1'b0;
   logic c_oe_prev = 1'b0;

   // Open-drain wired-AND of host and device; glitch_c injects pad noise.
   assign ps2c_i = (dev_c & ~ps2c_oe) ^ glitch_c;
   assign ps2d_i = dev_d & ~ps2d_oe;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_host_tx #(.CLK_FREQ_HZ(1_000_000), .FILTER_LEN(8)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .ps2c_i     (ps2c_i),
      .ps2d_i     (ps2d_i),
      .ps2c_oe_o  (ps2c_oe),
      .ps2d_oe_o  (ps2d_oe),
      .busy_o     (busy),
      .done_o     (done),
      .ack_err_o  (ack_err),
      .timeout_o  (timeout)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference frame as the device sees it: data LSB first, odd parity, stop.
   function automatic logic [9:0] exp_frame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b};
   endfunction

   always @(negedge clk) begin
      if (to_pending) begin
         to_ready_next = int'(tx_ready);
         to_pending = 1'b0;
      end
      if (done) begin
         done_cnt++;
         last_ack_err = int'(ack_err);
      end
      if (timeout) begin
         to_cnt++;
         to_cycle = cyc;
         to_c_oe = int'(ps2c_oe);
         to_d_oe = int'(ps2d_oe);
         to_pending = 1'b1;
      end
      if (ps2c_oe && !c_oe_prev) begin
         frame_starts++;
         inh_len = 0;
         inh_d = 0;
      end
      if (ps2c_oe) inh_len++;
      if (ps2c_oe && ps2d_oe) inh_d++;
      if (!ps2c_oe && c_oe_prev) begin
         last_inh = inh_len;
         last_inh_d = inh_d;
         req_cycle = cyc;
      end
      c_oe_prev = ps2c_oe;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tx_data = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Device: wait for request-to-send, then 11 clocks of 50+50 cycles.
   task automatic dev_frame(input bit do_ack, input int rst_edge, input bit noisy,
                            output logic [9:0] smp, output bit ok);
      int n;
      n = 0;
      smp = '0;
      ok = 1'b0;
      while (!(ps2c_i === 1'b1 && ps2d_i === 1'b0)) begin
         @(negedge clk);
         n++;
         if (n > 3000) return;
      end
      wait_cyc(40);
      for (int e = 1; e <= 11; e++) begin
         dev_c = 1'b0;
         if (e == rst_edge) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_c_oe", int'(ps2c_oe), 0);
            check("rst_d_oe", int'(ps2d_oe), 0);
            check("rst_busy", int'(busy), 0);
            rst = 1'b0;
            wait_cyc(50);
            dev_c = 1'b1;
            ok = 1'b1;
            return;
         end
         wait_cyc(50);
         if (e <= 10) smp[e-1] = ps2d_i;
         dev_c = 1'b1;
         if (noisy && e >= 2 && e <= 9) begin
            wait_cyc(20);
            dev_c = 1'b0;
            wait_cyc(3);
            dev_c = 1'b1;
            wait_cyc(27);
         end else if (e == 10 && do_ack) begin
            wait_cyc(25);
            dev_d = 1'b0;
            wait_cyc(25);
         end else begin
            wait_cyc(50);
         end
      end
      wait_cyc(10);
      dev_d = 1'b1;
      ok = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] b, input bit do_ack, input bit noisy,
                            input int rst_edge);
      logic [9:0] smp;
      bit ok;
      int d0, s0, t0, n;
      d0 = done_cnt;
      s0 = frame_starts;
      t0 = to_cnt;
      send_byte(b);
      if (noisy) begin
         wait_cyc(10);
         check("busy_in_inhibit", int'(busy), 1);
         tx_data = 8'hAA;
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
         wait_cyc(10);
         glitch_c = 1'b1;
         wait_cyc(3);
         glitch_c = 1'b0;
         wait_cyc(20);
         glitch_c = 1'b1;
         wait_cyc(3);
         glitch_c = 1'b0;
      end
      dev_frame(do_ack, rst_edge, noisy, smp, ok);
      check("dev_saw_rts", int'(ok), 1);
      if (rst_edge == 0) begin
         n = 0;
         while (done_cnt == d0 && n < 600) begin
            @(negedge clk);
            n++;
         end
         check("done_pulses", done_cnt - d0, 1);
         check("ack_err", last_ack_err, do_ack ? 0 : 1);
         check("frame_bits", int'(smp), int'(exp_frame(b)));
         check("inhibit_len", last_inh, 100);
         check("start_bit_len", last_inh_d, 1);
         wait_cyc(2);
         check("ready_after_done", int'(tx_ready), 1);
         wait_cyc(200);
         check("frame_starts", frame_starts - s0, 1);
         check("no_timeout", to_cnt - t0, 0);
      end else begin
         wait_cyc(300);
         check("rst_no_done", done_cnt - d0, 0);
         check("rst_no_timeout", to_cnt - t0, 0);
      end
   endtask

   initial begin
      #(10 * 200_000);
      $display("FAIL global_time_limit");
      $fatal(1, "time limit");
   end

   initial begin
      int t0, d0, n;
      logic [7:0] rb;
      bit ra;

      repeat (5) @(negedge clk);
      check("rst_ready", int'(tx_ready), 1);
      check("rst_busy_idle", int'(busy), 0);
      check("rst_oe", int'({ps2c_oe, ps2d_oe}), 0);
      check("rst_pulses", int'({done, ack_err, timeout}), 0);
      rst = 1'b0;
      wait_cyc(20);

      run_frame(8'hED, 1'b1, 1'b0, 0);
      run_frame(8'h01, 1'b0, 1'b0, 0);

      // Device never clocks: watchdog must fire.
      t0 = to_cnt;
      d0 = done_cnt;
      send_byte(8'hFF);
      n = 0;
      while (to_cnt == t0 && n < 25000) begin
         @(negedge clk);
         n++;
      end
      check("to_pulse", to_cnt - t0, 1);
      check("to_latency", to_cycle - req_cycle, 20000);
      check("to_c_oe", to_c_oe, 0);
      check("to_d_oe", to_d_oe, 0);
      wait_cyc(5);
      check("to_ready_next", to_ready_next, 1);
      check("to_single_pulse", to_cnt - t0, 1);
      check("to_no_done", done_cnt - d0, 0);

      run_frame(8'h01, 1'b1, 1'b0, 5);
      run_frame(8'h01, 1'b1, 1'b0, 0);
      run_frame(8'h3C, 1'b1, 1'b1, 0);

      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom_range(0, 255));
         ra = 1'($urandom_range(0, 1));
         run_frame(rb, ra, 1'($urandom_range(0, 1)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
